// File: rtl/phy_types_pkg.sv
// Shared PHY-link types: frame selector, transmitter state and symbol-count helper.
// No logic of its own; imported by the UART transmitter and its helpers.
// No flow control here.
package phy_types_pkg;

  // Frame type chosen by the link layer; NADA means "nothing to send".
  typedef enum logic [1:0] {
    NADA                = 2'd0,
    SELECT_COMMA_1_FLIT = 2'd1,
    SELECT_COMMA_2_FLIT = 2'd2,
    SELECT_COMMA_DATA   = 2'd3
  } comma_sel_t;

  // Transmitter frame phases.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Widest frame carries this many data symbols.
  localparam int MAX_SYMBOLS = 10;

  // Number of data symbols carried by a frame type; 0 flags an unusable selector.
  function automatic logic [3:0] comma_to_nsym(input comma_sel_t sel);
    case (sel)
      SELECT_COMMA_1_FLIT: comma_to_nsym = 4'd2;
      SELECT_COMMA_2_FLIT: comma_to_nsym = 4'd4;
      SELECT_COMMA_DATA:   comma_to_nsym = 4'd10;
      default:             comma_to_nsym = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/socetlib_counter.sv
// Generic up-counter with synchronous clear and wrap at a run-time limit.
// Count updates one cycle after count_enable; wraps to 0 after overflow_val.
// No backpressure; clear overrides enable.
module socetlib_counter #(
  parameter int NBITS = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [NBITS-1:0] overflow_val,
  output logic [NBITS-1:0] count_out
);

  // Count up on enable, wrapping to zero once the limit has been reached.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      if (count_out == overflow_val) count_out <= '0;
      else                           count_out <= count_out + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_baud.sv
// Baud-rate divider: modulo-CLKDIV_COUNT counter flagging the last cycle of each symbol.
// sym_tick is decoded straight from the count register (same cycle as count == CLKDIV_COUNT-1).
// No backpressure; clear holds the count at zero and overrides enable.
module uart_tx_baud #(
  parameter int CLKDIV_COUNT = 10
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic sym_tick
);

  // A divider of 1 would need a zero-width counter; keep at least one bit.
  localparam int CW = (CLKDIV_COUNT > 1) ? $clog2(CLKDIV_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKDIV_COUNT - 1);

  logic [CW-1:0] baud_cnt;

  assign sym_tick = (baud_cnt == LAST);

  // Free-run modulo CLKDIV_COUNT while enabled, park at zero when cleared.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      baud_cnt <= '0;
    end else if (clear) begin
      baud_cnt <= '0;
    end else if (enable) begin
      if (sym_tick) baud_cnt <= '0;
      else          baud_cnt <= baud_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Multi-lane UART transmitter: one start slice, N data slices MSB-first, then a high stop period.
// Line goes low 1 cycle after accept; done pulses (1+N+STOP_SYMBOLS)*CLKDIV_COUNT cycles after accept.
// start is only looked at in IDLE; requests while busy are dropped silently, bad requests pulse tx_err.
module uart_tx
  import phy_types_pkg::*;
#(
  parameter int PORTCOUNT    = 5,
  parameter int CLKDIV_COUNT = 10,
  parameter int STOP_SYMBOLS = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          start,
  input  comma_sel_t                    comma_sel,
  input  logic [MAX_SYMBOLS*PORTCOUNT-1:0] data,
  output logic                          busy,
  output logic                          done,
  output logic                          tx_err,
  output logic [PORTCOUNT-1:0]          uart_out
);

  localparam int DW = MAX_SYMBOLS * PORTCOUNT;
  localparam logic [2:0] STOP_LAST = 3'(STOP_SYMBOLS - 1);

  tx_state_t          state;
  logic [DW-1:0]      data_q;
  logic [3:0]         nsym_q;
  logic [2:0]         stop_cnt;

  logic [3:0]         req_nsym;
  logic               req_ok;
  logic               accept;
  logic               reject;
  logic               sym_tick;
  logic               rst_n;
  logic [3:0]         sym_k;
  logic [3:0]         sym_idx;
  logic               last_data;
  logic [PORTCOUNT-1:0] cur_slice;

  // A request is usable only if no transmitted slice looks like a start or stop slice.
  always_comb begin
    req_nsym = comma_to_nsym(comma_sel);
    req_ok   = (req_nsym != 4'd0);
    for (int b = 0; b < MAX_SYMBOLS; b++) begin
      if (4'(b) < req_nsym) begin
        if ((~|data[b*PORTCOUNT +: PORTCOUNT]) || (&data[b*PORTCOUNT +: PORTCOUNT]))
          req_ok = 1'b0;
      end
    end
  end

  assign accept = (state == IDLE) && start && req_ok;
  assign reject = (state == IDLE) && start && !req_ok;

  // The accept cycle counts as the first start-symbol cycle, so the divider runs from there.
  uart_tx_baud #(
    .CLKDIV_COUNT (CLKDIV_COUNT)
  ) u_baud (
    .CLK      (CLK),
    .RST      (RST),
    .clear    ((state == IDLE) && !accept),
    .enable   ((state != IDLE) || accept),
    .sym_tick (sym_tick)
  );

  assign rst_n = ~RST;

  // Counts data symbols already sent; the slice index runs the other way, N-1 down to 0.
  socetlib_counter #(
    .NBITS (4)
  ) u_sym_cnt (
    .CLK          (CLK),
    .nRST         (rst_n),
    .clear        (state != DATA),
    .count_enable ((state == DATA) && sym_tick),
    .overflow_val (nsym_q - 4'd1),
    .count_out    (sym_k)
  );

  assign sym_idx   = nsym_q - 4'd1 - sym_k;
  assign last_data = (sym_k == nsym_q - 4'd1);

  // Pick the latched slice for the current data symbol.
  always_comb begin
    cur_slice = '0;
    for (int b = 0; b < MAX_SYMBOLS; b++) begin
      if (sym_idx == 4'(b)) cur_slice = data_q[b*PORTCOUNT +: PORTCOUNT];
    end
  end

  // Frame sequencer; the line register shows the current state's symbol one cycle later.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      data_q   <= '0;
      nsym_q   <= '0;
      stop_cnt <= '0;
      uart_out <= '1;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_err   <= 1'b0;
    end else begin
      done   <= 1'b0;
      tx_err <= 1'b0;
      case (state)
        IDLE: begin
          stop_cnt <= '0;
          if (accept) begin
            data_q   <= data;
            nsym_q   <= req_nsym;
            uart_out <= '0;
            busy     <= 1'b1;
            state    <= START;
          end else begin
            uart_out <= '1;
            tx_err   <= reject;
          end
        end
        START: begin
          uart_out <= '0;
          if (sym_tick) state <= DATA;
        end
        DATA: begin
          uart_out <= cur_slice;
          if (sym_tick && last_data) begin
            stop_cnt <= '0;
            state    <= STOP;
          end
        end
        STOP: begin
          uart_out <= '1;
          if (sym_tick) begin
            if (stop_cnt == STOP_LAST) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              stop_cnt <= stop_cnt + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames, illegal requests, busy drops, back-to-back, reset.
// Expected line waveform is built from frame arithmetic; a mid-symbol sampler rebuilds the payload.
// Outputs are sampled on the falling edge, inputs driven there too.
module tb_uart_tx;
  import phy_types_pkg::*;

  localparam int P     = 5;
  localparam int DIV   = 10;
  localparam int STOPS = 2;
  localparam int W     = 10 * P;

  logic             CLK = 1'b0;
  logic             RST;
  logic             start;
  comma_sel_t       comma_sel;
  logic [W-1:0]     data;
  logic             busy;
  logic             done;
  logic             tx_err;
  logic [P-1:0]     uart_out;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx #(
    .PORTCOUNT    (P),
    .CLKDIV_COUNT (DIV),
    .STOP_SYMBOLS (STOPS)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .comma_sel (comma_sel),
    .data      (data),
    .busy      (busy),
    .done      (done),
    .tx_err    (tx_err),
    .uart_out  (uart_out)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int nsym_of(input comma_sel_t c);
    case (c)
      SELECT_COMMA_1_FLIT: return 2;
      SELECT_COMMA_2_FLIT: return 4;
      SELECT_COMMA_DATA:   return 10;
      default:             return 0;
    endcase
  endfunction

  function automatic logic [P-1:0] slice_of(input logic [W-1:0] d, input int b);
    return d[b*P +: P];
  endfunction

  // Transmitted slices avoid 00/1F; untransmitted ones may be anything.
  function automatic logic [W-1:0] rand_payload(input int n);
    logic [W-1:0] d;
    d = '0;
    for (int b = 0; b < 10; b++) begin
      if (b < n) d[b*P +: P] = 5'($urandom_range(1, 30));
      else       d[b*P +: P] = 5'($urandom_range(0, 31));
    end
    return d;
  endfunction

  function automatic logic [W-1:0] rand_word();
    return W'({$urandom, $urandom});
  endfunction

  // Send one frame and check every cycle from accept+1 to the done cycle.
  task automatic run_frame(input comma_sel_t c, input logic [W-1:0] d,
                           input bit hold, input bit scramble, input bit poke);
    int n;
    int len;
    int sym;
    logic [P-1:0] exp_line;
    logic [W-1:0] rx;
    logic [W-1:0] mask;
    n    = nsym_of(c);
    len  = (1 + n + STOPS) * DIV;
    rx   = '0;
    mask = '0;
    start     = 1'b1;
    comma_sel = c;
    data      = d;
    for (int t = 1; t <= len; t++) begin
      @(negedge CLK);
      sym = (t - DIV - 1) / DIV;
      if (t <= DIV)               exp_line = '0;
      else if (t <= DIV + DIV*n)  exp_line = slice_of(d, n - 1 - sym);
      else                        exp_line = '1;
      check($sformatf("line t=%0d n=%0d", t, n), 64'(uart_out), 64'(exp_line));
      check($sformatf("busy t=%0d", t), 64'(busy), 64'(t < len));
      check($sformatf("done t=%0d", t), 64'(done), 64'(t == len));
      check($sformatf("tx_err t=%0d", t), 64'(tx_err), 64'(0));
      if (t > DIV && t <= DIV + DIV*n && ((t - DIV - 1) % DIV) == DIV/2)
        rx[(n - 1 - sym)*P +: P] = uart_out;
      if (!hold) begin
        if (t == 1) start = 1'b0;
        if (scramble && t > 1) data = rand_word();
        if (poke && t == 15) begin
          start     = 1'b1;
          comma_sel = SELECT_COMMA_DATA;
          data      = rand_payload(10);
        end
        if (poke && t == 16) start = 1'b0;
      end
    end
    for (int b = 0; b < n; b++) mask[b*P +: P] = '1;
    check("rx payload", 64'(rx & mask), 64'(d & mask));
  endtask

  // One-cycle request that must be refused; DUT is idle on entry.
  task automatic reject_req(input string tag, input comma_sel_t c, input logic [W-1:0] d);
    start     = 1'b1;
    comma_sel = c;
    data      = d;
    @(negedge CLK);
    check({tag, " tx_err"}, 64'(tx_err), 64'(1));
    check({tag, " busy"}, 64'(busy), 64'(0));
    check({tag, " line"}, 64'(uart_out), 64'(5'h1F));
    start = 1'b0;
    @(negedge CLK);
    check({tag, " tx_err after"}, 64'(tx_err), 64'(0));
    check({tag, " busy after"}, 64'(busy), 64'(0));
    check({tag, " line after"}, 64'(uart_out), 64'(5'h1F));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] d;
    int done_seen;
    int low_seen;
    comma_sel_t c;

    RST       = 1'b1;
    start     = 1'b0;
    comma_sel = NADA;
    data      = '0;
    repeat (3) @(negedge CLK);
    check("reset line", 64'(uart_out), 64'(5'h1F));
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset tx_err", 64'(tx_err), 64'(0));
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("idle line", 64'(uart_out), 64'(5'h1F));

    // N=2: b1=0A, b0=15; b5=00 is outside the frame and must not block it.
    d = '0;
    d[0*P +: P] = 5'h15;
    d[1*P +: P] = 5'h0A;
    run_frame(SELECT_COMMA_1_FLIT, d, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);

    // N=10: b9..b0 = 01..0A, so 01 goes out first.
    d = '0;
    for (int b = 0; b < 10; b++) d[b*P +: P] = 5'(10 - b);
    run_frame(SELECT_COMMA_DATA, d, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);

    // Illegal requests.
    reject_req("nada", NADA, rand_payload(10));
    d = rand_payload(4);
    d[2*P +: P] = 5'h1F;
    reject_req("n4 slice2 ones", SELECT_COMMA_2_FLIT, d);
    d = rand_payload(10);
    d[7*P +: P] = 5'h00;
    reject_req("n10 slice7 zeros", SELECT_COMMA_DATA, d);

    // Start while busy is ignored and the payload is untouched.
    run_frame(SELECT_COMMA_2_FLIT, rand_payload(4), 1'b0, 1'b0, 1'b1);
    @(negedge CLK);

    // Back-to-back with start held: next frame begins right after done.
    d = rand_payload(4);
    run_frame(SELECT_COMMA_2_FLIT, d, 1'b1, 1'b0, 1'b0);
    run_frame(SELECT_COMMA_2_FLIT, d, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);

    // Random frames with the data bus churning mid-frame.
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 2))
        0:       c = SELECT_COMMA_1_FLIT;
        1:       c = SELECT_COMMA_2_FLIT;
        default: c = SELECT_COMMA_DATA;
      endcase
      run_frame(c, rand_payload(nsym_of(c)), 1'b0, 1'b1, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    // Reset in the middle of DATA abandons the frame at once.
    start     = 1'b1;
    comma_sel = SELECT_COMMA_DATA;
    data      = rand_payload(10);
    for (int t = 1; t <= 25; t++) begin
      @(negedge CLK);
      start = 1'b0;
    end
    #2 RST = 1'b1;
    #1;
    check("midframe reset line", 64'(uart_out), 64'(5'h1F));
    check("midframe reset busy", 64'(busy), 64'(0));
    check("midframe reset done", 64'(done), 64'(0));
    @(negedge CLK);
    RST = 1'b0;
    done_seen = 0;
    low_seen  = 0;
    for (int t = 0; t < 150; t++) begin
      @(negedge CLK);
      if (done) done_seen++;
      if (uart_out != 5'h1F) low_seen++;
    end
    check("no done after reset", 64'(done_seen), 64'(0));
    check("line idle after reset", 64'(low_seen), 64'(0));
    check("busy idle after reset", 64'(busy), 64'(0));

    // Still usable after the abort.
    run_frame(SELECT_COMMA_1_FLIT, rand_payload(2), 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Multi-lane UART transmitter that serializes one parallel word onto PORTCOUNT lines in lock-step.
- Sits directly upstream of the chiplet UART receiver, across the PHY link.
- A frame is one all-low start symbol, N data symbols (N = 2, 4 or 10, chosen by comma_sel), then an all-high stop period; the line idles high.
- All lanes share symbol timing, so the far side sees start and stop as all-lanes-low and all-lanes-high slices.

Parameters:
- PORTCOUNT, 5, number of parallel lanes.
- CLKDIV_COUNT, 10, CLK cycles per symbol.
- STOP_SYMBOLS, 2, stop-period length in symbols (legal range 2 to 7).

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous active-high reset.
- start  input  1  request to send; sampled only in IDLE.
- comma_sel  input  comma_sel_t (phy_types_pkg)  frame type. SELECT_COMMA_1_FLIT gives N=2, SELECT_COMMA_2_FLIT gives N=4, SELECT_COMMA_DATA gives N=10, NADA is illegal.
- data  input  10*PORTCOUNT  payload; bit b of lane i is data[b*PORTCOUNT+i].
- busy  output  1  high from the cycle after accept until the end of the stop period.
- done  output  1  one-cycle pulse on the last stop cycle.
- tx_err  output  1  one-cycle pulse when a request is rejected.
- uart_out  output  PORTCOUNT  serial lanes.

Behaviour:
- Reset: while RST is high, asynchronously, uart_out='1, busy=0, done=0, tx_err=0, FSM=IDLE, counters=0. This also applies mid-frame: the lines return high immediately and the frame is abandoned.
- FSM states: IDLE, START, DATA, STOP.
- IDLE, start=1 and request valid: latch data and N, go to START next cycle. uart_out drops to all-0 in that same first cycle, so latency is 1 cycle.
- Valid request: comma_sel != NADA, and for every transmitted symbol index b in [0, N-1] the slice data[b*PORTCOUNT +: PORTCOUNT] is neither all-0 nor all-1. The receiver treats those slices as start/stop, so they cannot be sent as data.
- Invalid request: tx_err=1 for one cycle, stay in IDLE, uart_out stays '1, nothing is latched.
- start while busy is ignored; no error is raised.
- Baud counter: 0..CLKDIV_COUNT-1, running in START/DATA/STOP, cleared in IDLE. sym_tick fires when it equals CLKDIV_COUNT-1.
- START: uart_out='0 for CLKDIV_COUNT cycles. On sym_tick go to DATA with symbol index = N-1.
- DATA: uart_out = latched slice at the current index; symbols go MSB first, index N-1 down to 0. Each symbol is held CLKDIV_COUNT cycles. On sym_tick, if index=0 go to STOP, else decrement the index. This order puts the first symbol at the receiver's highest shift-register position, so received bit b equals sent bit b.
- STOP: uart_out='1 for STOP_SYMBOLS*CLKDIV_COUNT cycles, counted with a 3-bit symbol counter. On the final sym_tick: done=1 that cycle, go to IDLE, busy falls.
- Back-to-back frames: a start in the first IDLE cycle after done is accepted. The minimum gap between frames is therefore the stop period.
- Frame length: accept cycle to done cycle inclusive is (1+N+STOP_SYMBOLS)*CLKDIV_COUNT cycles.
- Register outputs: uart_out, busy, done and tx_err are all driven from registers, with no combinational path from the inputs.
- The latched payload does not change while busy; changes on data mid-frame have no effect.
- Width rules: the baud counter is $clog2(CLKDIV_COUNT) bits wide and the symbol index is 4 bits.

Decomposition:
- phy_types_pkg:
  - Holds comma_sel_t (already exists).
  - Gains tx_state_t {IDLE, START, DATA, STOP}.
  - Gains a function comma_to_nsym(comma_sel_t) returning 2, 4, 10, or 0 for NADA.
- Sub-module uart_tx_baud: a modulo-CLKDIV_COUNT counter with clear and enable, producing sym_tick. The symbol index reuses socetlib_counter.

Test Plan (PORTCOUNT=5, CLKDIV_COUNT=10, STOP_SYMBOLS=2):
- Reset/idle: assert RST mid-DATA -> uart_out=5'h1F in the same cycle, busy=0; no done follows.
- SELECT_COMMA_1_FLIT with data slices b1=5'h0A, b0=5'h15 -> 10 cycles of 00, 10 of 0A, 10 of 15, 20 of 1F; done exactly 50 cycles after accept.
- SELECT_COMMA_DATA, slices b9..b0 = 01,02,...,0A -> lanes show 01 first and 0A last; done at cycle 130. Loopback into uart_rx gives done, comma_sel=SELECT_COMMA_DATA, and data equal to the sent data.
- Illegal requests: comma_sel=NADA, or slice b2=5'h1F with N=4 -> tx_err for 1 cycle, busy stays 0, uart_out stays 1F. With N=2, a slice b5=5'h00 is accepted because it is not transmitted.
- Busy rejection: pulse start at cycle 15 of a frame with different data -> ignored, no tx_err, and the original frame is sent unchanged.
- Back-to-back: hold start high with valid data -> second frame begins on the cycle after done. The line shows exactly 20 high cycles between frames.
